// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter: NUM_REQ producers share one FIFO write port,
// each grant lasting up to BURST_LEN words and honouring fifo_full backpressure.
module fifo_wr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic [NUM_REQ-1:0]            ack,
  output logic [NUM_REQ-1:0]            grant,
  input  logic                          fifo_full,
  output logic                          fifo_wr_en,
  output logic [DATA_WIDTH-1:0]         fifo_wrData
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);
  localparam logic [PTR_W-1:0] PTR_MAX  = PTR_W'(NUM_REQ - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d;
  logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [PTR_W-1:0]   k_q, k_d;

  logic [PTR_W-1:0]   pick;
  logic [PTR_W-1:0]   idx;
  int                 sum;

  // Scan from the farthest offset down so the requester nearest rr_ptr wins.
  always_comb begin
    pick = rr_ptr_q;
    idx  = rr_ptr_q;
    sum  = 0;
    for (int off = NUM_REQ - 1; off >= 0; off--) begin
      sum = int'(rr_ptr_q) + off;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      idx = PTR_W'(sum);
      if (req[idx]) pick = idx;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      grant_q  <= '0;
      rr_ptr_q <= '0;
      cnt_q    <= '0;
      k_q      <= '0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      cnt_q    <= cnt_d;
      k_q      <= k_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    cnt_d    = cnt_q;
    k_d      = k_q;
    case (state_q)
      IDLE: begin
        if (|req) begin
          state_d       = BUSY;
          grant_d       = '0;
          grant_d[pick] = 1'b1;
          k_d           = pick;
          cnt_d         = '0;
        end
      end
      BUSY: begin
        // A stalled final write does not complete the burst; fifo_wr_en already folds in fifo_full.
        if (!req[k_q] || (fifo_wr_en && (cnt_q == CNT_LAST))) begin
          state_d  = IDLE;
          grant_d  = '0;
          rr_ptr_d = (k_q == PTR_MAX) ? '0 : k_q + 1'b1;
          cnt_d    = '0;
        end else if (fifo_wr_en) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fifo_wr_en  = 1'b0;
    ack         = '0;
    fifo_wrData = '0;
    if (state_q == BUSY) begin
      fifo_wr_en  = req[k_q] & ~fifo_full;
      fifo_wrData = req_data[k_q*DATA_WIDTH +: DATA_WIDTH];
      if (fifo_wr_en) ack[k_q] = 1'b1;
    end
  end

  assign grant = grant_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed vector table, multi-cycle corner sequences,
// and a randomized run against a cycle-level reference model with per-requester ordering.
module tb_fifo_wr_arbiter;

  localparam int N = 4;
  localparam int W = 8;
  localparam int B = 4;

  logic           clock;
  logic           reset;
  logic [N-1:0]   req;
  logic [N*W-1:0] req_data;
  logic           fifo_full;
  logic [N-1:0]   ack;
  logic [N-1:0]   grant;
  logic           fifo_wr_en;
  logic [W-1:0]   fifo_wrData;

  fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(W), .BURST_LEN(B)) dut (
    .clock       (clock),
    .reset       (reset),
    .req         (req),
    .req_data    (req_data),
    .ack         (ack),
    .grant       (grant),
    .fifo_full   (fifo_full),
    .fifo_wr_en  (fifo_wr_en),
    .fifo_wrData (fifo_wrData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N-1:0] s_ack, s_grant;
  logic         s_wr;
  logic [W-1:0] s_data;

  // reference model state
  int m_owner;
  int m_cnt;
  int m_rr;

  typedef struct packed {
    logic [N-1:0] req;
    logic         full;
    logic [W-1:0] d0;
    logic [N-1:0] e_grant;
    logic         e_wr;
    logic [N-1:0] e_ack;
    logic [W-1:0] e_data;
  } vec_t;

  vec_t tv [10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // One clock cycle: sample outputs at the falling edge, return just after the rising edge.
  task automatic cyc();
    @(negedge clock);
    s_ack   = ack;
    s_grant = grant;
    s_wr    = fifo_wr_en;
    s_data  = fifo_wrData;
    @(posedge clock);
    #1;
  endtask

  task automatic reset_dut();
    reset     = 1'b1;
    req       = '0;
    req_data  = '0;
    fifo_full = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
  endtask

  task automatic model_expect(output logic [N-1:0] eg, output logic ew,
                              output logic [N-1:0] ea, output logic [W-1:0] ed);
    eg = '0; ew = 1'b0; ea = '0; ed = '0;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      ed = req_data[m_owner*W +: W];
      ew = req[m_owner] && !fifo_full;
      if (ew) ea[m_owner] = 1'b1;
    end
  endtask

  task automatic model_step();
    int  j;
    logic w;
    if (m_owner < 0) begin
      for (int off = 0; off < N; off++) begin
        j = (m_rr + off) % N;
        if (req[j] && m_owner < 0) m_owner = j;
      end
      m_cnt = 0;
    end else begin
      w = req[m_owner] && !fifo_full;
      if (w) m_cnt++;
      if (!req[m_owner] || m_cnt == B) begin
        m_rr    = (m_owner + 1) % N;
        m_owner = -1;
        m_cnt   = 0;
      end
    end
  endtask

  initial begin
    int seq [N];
    int sent [N];
    int log_idx [$];
    int log_dat [$];
    int n2;
    int wc;
    int ai;
    logic [N-1:0] eg, ea;
    logic         ew;
    logic [W-1:0] ed;

    tv[0] = '{4'b0001, 1'b0, 8'hA0, 4'b0000, 1'b0, 4'b0000, 8'h00};
    tv[1] = '{4'b0001, 1'b0, 8'hA0, 4'b0001, 1'b1, 4'b0001, 8'hA0};
    tv[2] = '{4'b0001, 1'b0, 8'hA1, 4'b0001, 1'b1, 4'b0001, 8'hA1};
    tv[3] = '{4'b0001, 1'b0, 8'hA2, 4'b0001, 1'b1, 4'b0001, 8'hA2};
    tv[4] = '{4'b0001, 1'b0, 8'hA3, 4'b0001, 1'b1, 4'b0001, 8'hA3};
    tv[5] = '{4'b0001, 1'b0, 8'hA4, 4'b0000, 1'b0, 4'b0000, 8'h00};
    tv[6] = '{4'b0001, 1'b0, 8'hA4, 4'b0001, 1'b1, 4'b0001, 8'hA4};
    tv[7] = '{4'b0001, 1'b0, 8'hA5, 4'b0001, 1'b1, 4'b0001, 8'hA5};
    tv[8] = '{4'b0000, 1'b0, 8'h5A, 4'b0001, 1'b0, 4'b0000, 8'h5A};
    tv[9] = '{4'b0000, 1'b0, 8'h5A, 4'b0000, 1'b0, 4'b0000, 8'h00};

    // Outputs while reset is held, even with every requester active
    reset     = 1'b1;
    req       = 4'b1111;
    req_data  = '1;
    fifo_full = 1'b0;
    #1;
    chk("rst_grant", 32'(grant), 32'(0));
    chk("rst_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("rst_ack",   32'(ack), 32'(0));
    chk("rst_data",  32'(fifo_wrData), 32'(0));

    // Single requester: burst of four, bubble, re-grant
    reset_dut();
    for (int r = 0; r < 10; r++) begin
      req       = tv[r].req;
      fifo_full = tv[r].full;
      req_data  = '0;
      req_data[0 +: W] = tv[r].d0;
      cyc();
      chk($sformatf("vec%0d_grant", r), 32'(s_grant), 32'(tv[r].e_grant));
      chk($sformatf("vec%0d_wr_en", r), 32'(s_wr),    32'(tv[r].e_wr));
      chk($sformatf("vec%0d_ack", r),   32'(s_ack),   32'(tv[r].e_ack));
      chk($sformatf("vec%0d_data", r),  32'(s_data),  32'(tv[r].e_data));
    end

    // All four requesters stream two words each
    reset_dut();
    for (int i = 0; i < N; i++) sent[i] = 0;
    for (int c = 0; c < 20; c++) begin
      for (int i = 0; i < N; i++) begin
        req[i] = (sent[i] < 2);
        req_data[i*W +: W] = 8'(16*i + sent[i]);
      end
      cyc();
      if (s_wr) begin
        ai = 0;
        for (int i = 0; i < N; i++) if (s_ack[i]) ai = i;
        log_idx.push_back(ai);
        log_dat.push_back(int'(s_data));
      end
      for (int i = 0; i < N; i++) if (s_ack[i]) sent[i]++;
    end
    chk("rr_write_count", 32'(log_idx.size()), 32'(8));
    for (int j = 0; j < 8 && j < log_idx.size(); j++) begin
      chk($sformatf("rr_owner%0d", j), 32'(log_idx[j]), 32'(j/2));
      chk($sformatf("rr_word%0d", j),  32'(log_dat[j]), 32'(16*(j/2) + j%2));
    end
    req = 4'b1111;
    cyc();
    cyc();
    chk("rr_wrap_to_0", 32'(s_grant), 32'(4'b0001));

    // Owner 2 stalled by fifo_full mid-burst for three cycles
    reset_dut();
    n2 = 0;
    for (int c = 0; c < 9; c++) begin
      req       = '0;
      req[2]    = (n2 < 4);
      req_data  = '0;
      req_data[2*W +: W] = 8'(8'hC0 + n2);
      fifo_full = (c >= 2 && c <= 4);
      cyc();
      chk($sformatf("full_c%0d_grant", c), 32'(s_grant),
          32'((c >= 1 && c <= 7) ? 4'b0100 : 4'b0000));
      chk($sformatf("full_c%0d_wr_en", c), 32'(s_wr),
          32'(c == 1 || (c >= 5 && c <= 7)));
      chk($sformatf("full_c%0d_ack", c), 32'(s_ack),
          32'((c == 1 || (c >= 5 && c <= 7)) ? 4'b0100 : 4'b0000));
      chk($sformatf("full_c%0d_data", c), 32'(s_data),
          32'((c >= 1 && c <= 7) ? 8'(8'hC0 + n2) : 8'h00));
      if (s_ack[2]) n2++;
    end

    // Pointer now at 3: requester 3 beats 0, then 0 wins after the wrap
    fifo_full = 1'b0;
    req       = 4'b1001;
    req_data  = '0;
    req_data[0 +: W]   = 8'hD0;
    req_data[3*W +: W] = 8'hD3;
    cyc();
    cyc();
    chk("wrap_grant3", 32'(s_grant), 32'(4'b1000));
    chk("wrap_ack3",   32'(s_ack),   32'(4'b1000));
    chk("wrap_data3",  32'(s_data),  32'(8'hD3));
    req = 4'b0001;
    cyc();
    chk("wrap_hold3", 32'(s_grant), 32'(4'b1000));
    chk("wrap_nowr3", 32'(s_wr), 32'(0));
    req = 4'b1001;
    req_data[3*W +: W] = 8'hD4;
    cyc();
    chk("wrap_bubble", 32'(s_grant), 32'(0));

    // Reset lands while owner 0 is writing
    #1;
    chk("busy_grant0", 32'(grant), 32'(4'b0001));
    chk("busy_wr_en",  32'(fifo_wr_en), 32'(1));
    chk("busy_data",   32'(fifo_wrData), 32'(8'hD0));
    reset = 1'b1;
    #1;
    chk("async_grant", 32'(grant), 32'(0));
    chk("async_wr_en", 32'(fifo_wr_en), 32'(0));
    chk("async_ack",   32'(ack), 32'(0));
    chk("async_data",  32'(fifo_wrData), 32'(0));
    @(posedge clock);
    #1;
    reset = 1'b0;
    req   = 4'b1010;
    cyc();
    chk("post_rst_idle", 32'(s_grant), 32'(0));
    cyc();
    chk("post_rst_grant", 32'(s_grant), 32'(4'b0010));

    // Randomized traffic against the reference model
    reset_dut();
    m_owner = -1;
    m_cnt   = 0;
    m_rr    = 0;
    wc      = 0;
    for (int i = 0; i < N; i++) begin
      seq[i] = 0;
      req_data[i*W +: W] = {2'(i), 6'(seq[i])};
    end
    for (int c = 0; c < 2000; c++) begin
      model_expect(eg, ew, ea, ed);
      cyc();
      chk("rnd_grant", 32'(s_grant), 32'(eg));
      chk("rnd_wr_en", 32'(s_wr),    32'(ew));
      chk("rnd_ack",   32'(s_ack),   32'(ea));
      chk("rnd_data",  32'(s_data),  32'(ed));
      chk("rnd_write_when_full", 32'(s_wr & fifo_full), 32'(0));
      chk("rnd_grant_onehot0", 32'($onehot0(s_grant)), 32'(1));
      if (s_grant == '0) wc = 0;
      if (s_wr) begin
        wc++;
        chk("rnd_burst_len", 32'(wc > B), 32'(0));
        chk("rnd_ack_is_grant", 32'(s_ack), 32'(s_grant));
        ai = 0;
        for (int i = 0; i < N; i++) if (s_ack[i]) ai = i;
        chk("rnd_order", 32'(s_data), 32'({2'(ai), 6'(seq[ai])}));
      end
      model_step();
      for (int i = 0; i < N; i++) begin
        if (s_ack[i]) begin
          seq[i]++;
          req[i] = ($urandom_range(0, 1) == 1);
        end else if (!req[i]) begin
          req[i] = ($urandom_range(0, 9) < 4);
        end
        req_data[i*W +: W] = {2'(i), 6'(seq[i])};
      end
      fifo_full = ($urandom_range(0, 9) < 3);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write arbiter that lets NUM_REQ requesters share the single write port of one synchronous FIFO.
- Sits between the producers and the FIFO's wr_en/wrData/full pins.
- Grants one requester at a time for a burst of up to BURST_LEN words, honouring FIFO backpressure through fifo_full.

Parameters:
- NUM_REQ, 4, number of requesters; >= 2.
- DATA_WIDTH, 8, word width; equals the FIFO data width.
- BURST_LEN, 4, maximum words written per grant before forced release; >= 1.

Ports:
- clock  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester request; bit i high means requester i has a word on its data slice.
- req_data  input  NUM_REQ*DATA_WIDTH  flattened data; slice i is [i*DATA_WIDTH +: DATA_WIDTH].
- ack  output  NUM_REQ  combinational; bit i high means requester i's word is written this cycle.
- grant  output  NUM_REQ  registered one-hot (or zero) ownership vector.
- fifo_full  input  1  FIFO full flag.
- fifo_wr_en  output  1  FIFO write enable, combinational.
- fifo_wrData  output  DATA_WIDTH  FIFO write data, combinational mux.

Behaviour:
- Internal state:
  - FSM: IDLE, BUSY.
  - rr_ptr: index, width $clog2(NUM_REQ), wraps NUM_REQ-1 -> 0.
  - burst counter: width $clog2(BURST_LEN+1).
  - owner index k.
- Reset (async): state=IDLE, grant=0, rr_ptr=0, cnt=0, k=0.
  - Outputs during reset: fifo_wr_en=0, ack=0, fifo_wrData=0.
  - Reset asserted mid-burst aborts the burst immediately; no partial-cycle write is issued.
- IDLE:
  - fifo_wr_en=0, ack=0, fifo_wrData=0.
  - If req!=0: select the first i with req[i]=1, searching rr_ptr, rr_ptr+1, ... mod NUM_REQ.
  - Next edge: grant<=onehot(i), k<=i, cnt<=0, state<=BUSY.
  - If req==0: remain IDLE.
  - Arbitration costs exactly one cycle; no write occurs in the IDLE cycle.
- BUSY (owner k):
  - fifo_wr_en = req[k] & ~fifo_full.
  - ack = onehot(k) when fifo_wr_en=1, else 0; ack bits for non-owners are always 0.
  - fifo_wrData = req_data slice k whenever BUSY, regardless of fifo_wr_en.
  - On a write, cnt increments.
  - Release conditions, both taking effect at the next edge:
    - (a) a write occurs while cnt==BURST_LEN-1;
    - (b) req[k]==0.
  - On release: grant<=0, rr_ptr<=(k+1) mod NUM_REQ, cnt<=0, state<=IDLE.
  - fifo_full=1 with req[k]=1: hold the grant, no write, cnt unchanged. No timeout; ownership persists until the FIFO drains.
- Requester contract:
  - Hold req and the data slice stable until ack is seen.
  - Requests from non-owners are ignored (no ack) until a later arbitration.
- Throughput:
  - Max BURST_LEN words per BURST_LEN+1 cycles: a burst plus one IDLE bubble.
  - A single requester with continuous req re-wins after each bubble.
- Fairness: requesters are visited in order; each owner is lowest priority at the next arbitration.
- Simultaneous events:
  - The owner's final write and fifo_full rising in the same cycle: fifo_full gates the write, so the burst does not complete and the grant is held.
  - req[k] dropping in the same cycle as fifo_full: release, no write.
- Invariants:
  - grant is one-hot in BUSY and zero in IDLE.
  - fifo_wr_en implies exactly one ack bit set and that bit is the grant bit.
  - Never write while fifo_full=1.

Test Plan:
- Reset then req=4'b0001, data0=8'hA0..A5 advancing on ack, fifo_full=0, BURST_LEN=4:
  - grant=0001 one cycle after req.
  - Writes A0,A1,A2,A3 on 4 consecutive cycles, then 1 IDLE bubble.
  - Re-grant; writes A4,A5.
- req=4'b1111 held, each requester streams 2 words, BURST_LEN=4, no full:
  - Grant order 0,1,2,3.
  - Each burst ends by req drop after 2 writes.
  - rr_ptr=0 after requester 3 releases.
- Owner 2 mid-burst (cnt=1), fifo_full=1 for 3 cycles:
  - fifo_wr_en=0 and ack=0 throughout; grant stays 0100; cnt stays 1.
  - After full drops, 3 more writes complete the burst.
- rr_ptr=3, req=4'b1001 → requester 3 wins. Next arbitration with req=4'b1001 → requester 0 wins (wrap-around).
- Reset asserted during BUSY with fifo_wr_en=1:
  - Asynchronously grant=0, fifo_wr_en=0.
  - After release, req=4'b0010 is granted from rr_ptr=0 search → requester 1.
- Scoreboard over 2000 random cycles (random req and fifo_full):
  - Never fifo_wr_en with fifo_full.
  - grant always one-hot or zero.
  - ≤ BURST_LEN writes per grant.
  - Every acked word appears on fifo_wrData in order per requester.
